alu_sequencer: RTL and testbench

Parametrised, multi-cycle successor to the calculator's combinational ALU operand selection. It accepts one arithmetic request at a time over a valid/ready handshake and executes it, iterating internally for multiply, divide and digit-append/backspace. It returns a registered result with status flags over a second valid/ready handshake. It sits between the calculator controller FSM and the data stack: the controller issues `op`/`a`/`b` and waits for the response instead of relying on single-cycle combinational results.

---
 rtl/alu_sequencer_pkg.sv | 36 +++
 rtl/alu_seq_muldiv.sv | 117 +++++++++++
 rtl/alu_sequencer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared ALU interface definitions.
// Holds the 3-bit op codes (AC_*), the sequencer state encoding and small op-class helpers.
// The controller, the sequencer and the bench all import this package.

package alu_sequencer_pkg;

  localparam logic [2:0] AC_ADD    = 3'd0;
  localparam logic [2:0] AC_SUB    = 3'd1;
  localparam logic [2:0] AC_MUL    = 3'd2;
  localparam logic [2:0] AC_DIV    = 3'd3;
  localparam logic [2:0] AC_APPEND = 3'd4;
  localparam logic [2:0] AC_BACK   = 3'd5;
  localparam logic [2:0] AC_NEG    = 3'd6;
  localparam logic [2:0] AC_POS    = 3'd7;

  // StExec is the single evaluation cycle for the non-iterative ops and for errors.
  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StMul,
    StApp,
    StDiv,
    StDone
  } alu_seq_state_e;

  // Ops that run through the shift-add multiplier.
  function automatic logic ac_is_mul(input logic [2:0] op);
    return (op == AC_MUL) || (op == AC_APPEND);
  endfunction

  // Ops that run through the restoring divider.
  function automatic logic ac_is_div(input logic [2:0] op);
    return (op == AC_DIV) || (op == AC_BACK);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative unsigned magnitude multiplier / divider.
// One bit per cycle for WIDTH cycles after i_start; o_done pulses for one cycle after the
// last iteration. i_abort (or reset) clears any run in progress.
// Optional feature macro: ALU_SEQ_DIV_EN (divider half present only when defined).
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_abort         cancel current run
//   i_start         load operands and start (ignored fields for the unused half)
//   i_div           1 = divide i_a by i_b, 0 = multiply i_a by i_b
//   i_a, i_b        unsigned magnitudes
//   o_busy, o_done  iterating / one-cycle completion pulse
//   o_prod          2*WIDTH-bit product
//   o_quo           WIDTH-bit quotient (0 when the divider is compiled out)

module alu_seq_muldiv #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_abort,
  input  logic                 i_start,
  input  logic                 i_div,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_prod,
  output logic [WIDTH-1:0]     o_quo
);

  localparam int unsigned      CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0]  CntInit = CntW'(WIDTH);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);

  logic                 r_busy;
  logic                 r_done;
  logic [CntW-1:0]      r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dsor;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  // Dividend bits shift out of the top of r_quo while quotient bits shift in at the bottom.
  assign w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dsor};
  assign o_quo   = r_quo;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_abort) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dsor <= '0;
    end else if (i_start) begin
      if (i_div) begin
        r_rem  <= '0;
        r_quo  <= i_a;
        r_dsor <= i_b;
      end
    end else if (r_busy) begin
      if (!w_trial[WIDTH]) begin
        r_rem <= w_trial;
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_shift;
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
    end
  end
`else
  assign o_quo = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_abort) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy <= 1'b1;
        r_cnt  <= CntInit;
        if (!i_div) begin
          r_acc    <= '0;
          r_mcand  <= {{WIDTH{1'b0}}, i_a};
          r_mplier <= i_b;
        end
      end else if (r_busy) begin
        r_cnt    <= r_cnt - CntOne;
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        if (r_cnt == CntOne) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_prod = r_acc;

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle signed ALU with request/response valid-ready handshakes.
// One request in flight at a time; result and flags are registered.
// Optional feature macro: ALU_SEQ_DIV_EN (DIV/BACK supported only when defined; otherwise
// they complete after one cycle with rsp_err=1, rsp_data=0).
// Ports:
//   Clock, Reset        clock, synchronous active-low reset
//   abort               drop any in-flight or undelivered result on the next edge
//   req_valid/req_ready request handshake; req_op (AC_*), req_a, req_b operands
//   rsp_valid/rsp_ready response handshake; rsp_data result, rsp_ovf overflow,
//                       rsp_err illegal op (divide by zero, op compiled out)

module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BASE  = 10
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             abort,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_err
);

  localparam int unsigned      W2    = 2 * WIDTH;
  localparam logic [WIDTH-1:0] BaseW = WIDTH'(BASE);
  localparam logic [WIDTH-1:0] MinW  = {1'b1, {(WIDTH-1){1'b0}}};

  alu_seq_state_e   r_state;
  alu_seq_state_e   w_state_next;

  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [W2-1:0]    r_prod;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_ovf;
  logic             r_rsp_err;

  logic             w_accept;
  logic             w_div_go;
  logic             w_md_start;
  logic             w_md_busy;
  logic             w_md_done;
  logic [W2-1:0]    w_md_prod;
  logic [WIDTH-1:0] w_md_quo;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_md_b;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_neg;
  logic             w_prod_neg;
  logic [W2-1:0]    w_prod_signed;
  logic [W2-1:0]    w_app_sum;

  logic             w_load;
  logic [WIDTH-1:0] w_data_d;
  logic             w_ovf_d;
  logic             w_err_d;
  logic             w_prod_load;

  logic             w_unused_busy;

  // Exact result held in W2 bits; overflow if the discarded high half is not a sign extension.
  function automatic logic f_trunc_ovf(input logic [W2-1:0] v);
    return v[W2-1:WIDTH] != {WIDTH{v[WIDTH-1]}};
  endfunction

  assign w_accept = req_valid && req_ready;

  assign w_a_mag = req_a[WIDTH-1] ? (-req_a) : req_a;
  assign w_b_mag = req_b[WIDTH-1] ? (-req_b) : req_b;
  // APPEND and BACK use the radix as the second magnitude operand.
  assign w_md_b  = ((req_op == AC_MUL) || (req_op == AC_DIV)) ? w_b_mag : BaseW;

`ifdef ALU_SEQ_DIV_EN
  assign w_div_go = ac_is_div(req_op) && !((req_op == AC_DIV) && (req_b == '0));
`else
  assign w_div_go = 1'b0;
`endif

  assign w_md_start = w_accept && (ac_is_mul(req_op) || w_div_go);

  alu_seq_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_abort (abort),
    .i_start (w_md_start),
    .i_div   (ac_is_div(req_op)),
    .i_a     (w_a_mag),
    .i_b     (w_md_b),
    .o_busy  (w_md_busy),
    .o_done  (w_md_done),
    .o_prod  (w_md_prod),
    .o_quo   (w_md_quo)
  );

  assign w_unused_busy = w_md_busy;

  // State register: reset has priority over abort; both force IDLE.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= StIdle;
    end else if (abort) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (ac_is_mul(req_op)) begin
            w_state_next = StMul;
          end else if (w_div_go) begin
            w_state_next = StDiv;
          end else begin
            w_state_next = StExec;
          end
        end
      end
      StExec: w_state_next = StDone;
      StMul: begin
        if (w_md_done) begin
          w_state_next = (r_op == AC_APPEND) ? StApp : StDone;
        end
      end
      StApp: w_state_next = StDone;
      StDiv: begin
        if (w_md_done) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs. Reset and abort gate req_ready so no accept coincides with either.
  always_comb begin
    req_ready = (r_state == StIdle) && Reset && !abort;
    rsp_valid = (r_state == StDone);
  end

  // Result datapath.
  assign w_sum         = r_a + r_b;
  assign w_diff        = r_a - r_b;
  assign w_neg         = -r_a;
  assign w_prod_neg    = r_a[WIDTH-1] ^ ((r_op == AC_MUL) && r_b[WIDTH-1]);
  assign w_prod_signed = w_prod_neg ? (-w_md_prod) : w_md_prod;
  assign w_app_sum     = r_prod + {{WIDTH{r_b[WIDTH-1]}}, r_b};

`ifdef ALU_SEQ_DIV_EN
  logic             w_quo_neg;
  logic [WIDTH-1:0] w_quo_signed;
  assign w_quo_neg    = r_a[WIDTH-1] ^ ((r_op == AC_DIV) && r_b[WIDTH-1]);
  assign w_quo_signed = w_quo_neg ? (-w_md_quo) : w_md_quo;
`else
  logic w_unused_quo;
  assign w_unused_quo = ^w_md_quo;
`endif

  always_comb begin
    w_load      = 1'b0;
    w_data_d    = '0;
    w_ovf_d     = 1'b0;
    w_err_d     = 1'b0;
    w_prod_load = 1'b0;
    unique case (r_state)
      StExec: begin
        w_load = 1'b1;
        case (r_op)
          AC_ADD: begin
            w_data_d = w_sum;
            w_ovf_d  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
          end
          AC_SUB: begin
            w_data_d = w_diff;
            w_ovf_d  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
          end
          AC_NEG: begin
            w_data_d = w_neg;
            w_ovf_d  = (r_a == MinW);
          end
          AC_POS: w_data_d = r_a;
          // Divide by zero, or DIV/BACK with the divider compiled out.
          default: w_err_d = 1'b1;
        endcase
      end
      StMul: begin
        if (w_md_done) begin
          if (r_op == AC_APPEND) begin
            w_prod_load = 1'b1;
          end else begin
            w_load   = 1'b1;
            w_data_d = w_prod_signed[WIDTH-1:0];
            w_ovf_d  = f_trunc_ovf(w_prod_signed);
          end
        end
      end
      StApp: begin
        w_load   = 1'b1;
        w_data_d = w_app_sum[WIDTH-1:0];
        w_ovf_d  = f_trunc_ovf(w_app_sum);
      end
`ifdef ALU_SEQ_DIV_EN
      StDiv: begin
        if (w_md_done) begin
          w_load   = 1'b1;
          w_data_d = w_quo_signed;
          // Only MIN / -1 yields a positive quotient magnitude of 2^(WIDTH-1).
          w_ovf_d  = !w_quo_neg && w_md_quo[WIDTH-1];
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_prod     <= '0;
      r_rsp_data <= '0;
      r_rsp_ovf  <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= req_op;
        r_a  <= req_a;
        r_b  <= req_b;
      end
      if (w_prod_load) begin
        r_prod <= w_prod_signed;
      end
      if (w_load) begin
        r_rsp_data <= w_data_d;
        r_rsp_ovf  <= w_ovf_d;
        r_rsp_err  <= w_err_d;
      end
    end
  end

  assign rsp_data = r_rsp_data;
  assign rsp_ovf  = r_rsp_ovf;
  assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vector table plus hand-written backpressure and abort sequences
// for alu_sequencer at WIDTH=16, BASE=10. Honours ALU_SEQ_DIV_EN for DIV/BACK expectations.

module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        abort;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_ovf;
  logic        rsp_err;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic        ovf;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_sequencer #(
    .WIDTH (16),
    .BASE  (10)
  ) dut (
    .Clock     (clk),
    .Reset     (rst_n),
    .abort     (abort),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request; returns the edge number (accept = edge 0) at which rsp_valid is seen.
  task automatic do_req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic deliver(input string name);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({name, "_drop"}, rsp_valid, 0);
  endtask

  initial begin
    int lat;
    int seen;

    vecs.push_back('{"add_2_3",        AC_ADD,    16'd2,    16'd3,    16'd5,    0, 0, 1});
    vecs.push_back('{"add_ovf",        AC_ADD,    16'h7FFF, 16'd1,    16'h8000, 1, 0, 1});
    vecs.push_back('{"sub_min_1",      AC_SUB,    16'h8000, 16'd1,    16'h7FFF, 1, 0, 1});
    vecs.push_back('{"neg_min",        AC_NEG,    16'h8000, 16'd0,    16'h8000, 1, 0, 1});
    vecs.push_back('{"neg_5",          AC_NEG,    16'd5,    16'd0,    16'hFFFB, 0, 0, 1});
    vecs.push_back('{"pos_m7",         AC_POS,    16'hFFF9, 16'd9,    16'hFFF9, 0, 0, 1});
    vecs.push_back('{"mul_300_300",    AC_MUL,    16'd300,  16'd300,  16'h5F90, 1, 0, 17});
    vecs.push_back('{"mul_6_7",        AC_MUL,    16'd6,    16'd7,    16'd42,   0, 0, 17});
    vecs.push_back('{"mul_m3_5",       AC_MUL,    16'hFFFD, 16'd5,    16'hFFF1, 0, 0, 17});
    vecs.push_back('{"mul_m256_128",   AC_MUL,    16'hFF00, 16'd128,  16'h8000, 0, 0, 17});
    vecs.push_back('{"app_123_4",      AC_APPEND, 16'd123,  16'd4,    16'd1234, 0, 0, 18});
    vecs.push_back('{"app_m12_5",      AC_APPEND, 16'hFFF4, 16'd5,    16'hFF8D, 0, 0, 18});
    vecs.push_back('{"app_ovf",        AC_APPEND, 16'd3276, 16'd8,    16'h8000, 1, 0, 18});
`ifdef ALU_SEQ_DIV_EN
    vecs.push_back('{"div_m7_2",       AC_DIV,    16'hFFF9, 16'd2,    16'hFFFD, 0, 0, 17});
    vecs.push_back('{"div_min_m1",     AC_DIV,    16'h8000, 16'hFFFF, 16'h8000, 1, 0, 17});
    vecs.push_back('{"div_by_0",       AC_DIV,    16'd5,    16'd0,    16'd0,    0, 1, 1});
    vecs.push_back('{"back_1234",      AC_BACK,   16'd1234, 16'd0,    16'd123,  0, 0, 17});
    vecs.push_back('{"back_m1234",     AC_BACK,   16'hFB2E, 16'd0,    16'hFF85, 0, 0, 17});
`else
    vecs.push_back('{"div_off_8_2",    AC_DIV,    16'd8,    16'd2,    16'd0,    0, 1, 1});
    vecs.push_back('{"div_off_by_0",   AC_DIV,    16'd5,    16'd0,    16'd0,    0, 1, 1});
    vecs.push_back('{"back_off_1234",  AC_BACK,   16'd1234, 16'd0,    16'd0,    0, 1, 1});
`endif

    rst_n     = 1'b0;
    abort     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data",  rsp_data,  0);
    check("rst_rsp_ovf",   rsp_ovf,   0);
    check("rst_rsp_err",   rsp_err,   0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready_after", req_ready, 1);

    // Vector table.
    foreach (vecs[i]) begin
      do_req(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check({vecs[i].name, "_lat"},  lat,       vecs[i].lat);
      check({vecs[i].name, "_data"}, rsp_data,  vecs[i].data);
      check({vecs[i].name, "_ovf"},  rsp_ovf,   vecs[i].ovf);
      check({vecs[i].name, "_err"},  rsp_err,   vecs[i].err);
      check({vecs[i].name, "_busy"}, req_ready, 0);
      deliver(vecs[i].name);
    end

    // Backpressure: response held stable while rsp_ready is low.
    do_req(AC_SUB, 16'd5, 16'd9, lat);
    check("bp_lat", lat, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_hold_data",  rsp_data,  16'hFFFC);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp_done_valid", rsp_valid, 0);
    check("bp_done_ready", req_ready, 1);

    // Abort during MUL: raised after edge 5, sampled at edge 6.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = AC_MUL;
    req_a     = 16'd300;
    req_b     = 16'd300;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    #1;
    check("abort_ready_low", req_ready, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    #1;
    check("abort_idle_ready", req_ready, 1);
    check("abort_no_valid",   rsp_valid, 0);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1;
    end
    check("abort_no_late_rsp", seen, 0);
    do_req(AC_ADD, 16'd2, 16'd3, lat);
    check("post_abort_lat",  lat,      1);
    check("post_abort_data", rsp_data, 16'd5);
    deliver("post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
